// File: rtl/ws2801_driver_pkg.sv
// Shared types and constants for the WS2801 LED chain transmitter.
package ws2801_pkg;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

  // Transmitter FSM states:
  //   ST_IDLE     | line idle, waiting for start
  //   ST_LOAD     | requesting the next pixel, sck held low
  //   ST_SHIFT_LO | current bit on sdo, sck low
  //   ST_SHIFT_HI | sck high, sdo held
  //   ST_LATCH    | line idle so the whole chain latches
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH
  } state_e;

  // Minimum idle time the driver chips need to latch, and their fastest clock.
  localparam int unsigned WS2801_LATCH_NS   = 500_000;
  localparam int unsigned WS2801_MAX_SCK_HZ = 25_000_000;

endpackage

// File: rtl/ws2801_driver_if.sv
// Pixel stream and frame control between pattern logic and the transmitter.
interface ws2801_driver_if;
  import ws2801_pkg::*;

  logic start;
  rgb_t pix_data;
  logic pix_valid;
  logic pix_ready;
  logic busy;
  logic done;

  modport master (
    output start, pix_data, pix_valid,
    input  pix_ready, busy, done
  );

  modport slave (
    input  start, pix_data, pix_valid,
    output pix_ready, busy, done
  );

endinterface

// File: rtl/ws2801_driver_bit_timer.sv
// Half-period timer for sck: strobes phase_end on the last cycle of each phase.
module ws2801_bit_timer #(
  parameter int unsigned HALF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic phase_end
);

  localparam int unsigned W = $clog2(HALF + 1);
  localparam logic [W-1:0] RELOAD = W'(HALF - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Down-count while shifting; reload at terminal count or when idle.
  always_comb begin
    phase_end = run && (cnt_q == '0);
    cnt_d     = cnt_q - 1'b1;
    if (!run || phase_end) cnt_d = RELOAD;
  end

  // Phase counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ws2801_driver.sv
// WS2801 chain transmitter: takes one RGB pixel per LED and shifts it out
// MSB-first on sdo/sck, then idles the line long enough for the chain to latch.
module ws2801_driver
  import ws2801_pkg::*;
#(
  parameter int unsigned LEDS         = 5,
  parameter int unsigned HALF         = 2,
  parameter int unsigned LATCH_CYCLES = 25_100
) (
  input  logic             clk,
  input  logic             rst_n,
  ws2801_driver_if.slave   bus,
  output logic             sdo,
  output logic             sck
);

  localparam int unsigned PW = $clog2(LEDS + 1);
  localparam int unsigned LW = $clog2(LATCH_CYCLES + 1);
  localparam logic [PW-1:0] LAST_PIX   = PW'(LEDS - 1);
  localparam logic [LW-1:0] LATCH_LOAD = LW'(LATCH_CYCLES - 1);

  state_e        state_q, state_d;
  logic [22:0]   shreg_q, shreg_d;
  logic [4:0]    bit_q, bit_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          sck_q, sck_d;
  logic          sdo_q, sdo_d;
  logic          rdy_q, rdy_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          phase_end;
  logic [23:0]   pix_bits;

  assign pix_bits = bus.pix_data;

  ws2801_bit_timer #(.HALF(HALF)) u_bit_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       ((state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI)),
    .phase_end (phase_end)
  );

  // Next state, counters, and the registered outputs derived from the next state.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    pix_d   = pix_q;
    lat_d   = lat_q;
    sdo_d   = sdo_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // busy_q is still high in the done cycle, which masks a start there.
        if (bus.start && !busy_q) begin
          state_d = ST_LOAD;
          pix_d   = '0;
        end
      end
      ST_LOAD: begin
        if (bus.pix_valid && rdy_q) begin
          shreg_d = pix_bits[22:0];
          sdo_d   = pix_bits[23];
          bit_d   = 5'd23;
          state_d = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_LO: begin
        if (phase_end) state_d = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        if (phase_end) begin
          if (bit_q != 5'd0) begin
            bit_d   = bit_q - 5'd1;
            sdo_d   = shreg_q[22];
            shreg_d = {shreg_q[21:0], 1'b0};
            state_d = ST_SHIFT_LO;
          end else if (pix_q < LAST_PIX) begin
            pix_d   = pix_q + 1'b1;
            state_d = ST_LOAD;
          end else begin
            lat_d   = LATCH_LOAD;
            state_d = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        if (lat_q == '0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_d == ST_IDLE) || (state_d == ST_LATCH)) sdo_d = 1'b0;
    sck_d  = (state_d == ST_SHIFT_HI);
    rdy_d  = (state_d == ST_LOAD);
    busy_d = (state_d != ST_IDLE) || done_d;
  end

  // State, datapath and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      pix_q   <= '0;
      lat_q   <= '0;
      sck_q   <= 1'b0;
      sdo_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      pix_q   <= pix_d;
      lat_q   <= lat_d;
      sck_q   <= sck_d;
      sdo_q   <= sdo_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sck           = sck_q;
  assign sdo           = sdo_q;
  assign bus.pix_ready = rdy_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_ws2801_driver.sv
// Directed bench: a 5-LED/HALF=2 instance and a 1-LED/HALF=1 instance, each
// watched by a behavioural strip receiver that captures sdo on sck rises.
module tb_ws2801_driver;

  localparam int LEDS_A = 5, HALF_A = 2, LAT_A = 100;
  localparam int LEDS_B = 1, HALF_B = 1, LAT_B = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a, rst_n_b;
  logic sdo_a, sck_a, sdo_b, sck_b;

  ws2801_driver_if if_a ();
  ws2801_driver_if if_b ();

  ws2801_driver #(.LEDS(LEDS_A), .HALF(HALF_A), .LATCH_CYCLES(LAT_A)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .bus(if_a.slave), .sdo(sdo_a), .sck(sck_a));
  ws2801_driver #(.LEDS(LEDS_B), .HALF(HALF_B), .LATCH_CYCLES(LAT_B)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .bus(if_b.slave), .sdo(sdo_b), .sck(sck_b));

  logic [1:0]  start_v, valid_v;
  logic [23:0] data_v [2];
  logic [1:0]  sck_v, sdo_v, rdy_v, busy_v, done_v;

  assign if_a.start     = start_v[0];
  assign if_a.pix_valid = valid_v[0];
  assign if_a.pix_data  = data_v[0];
  assign if_b.start     = start_v[1];
  assign if_b.pix_valid = valid_v[1];
  assign if_b.pix_data  = data_v[1];
  assign sck_v  = {sck_b, sck_a};
  assign sdo_v  = {sdo_b, sdo_a};
  assign rdy_v  = {if_b.pix_ready, if_a.pix_ready};
  assign busy_v = {if_b.busy, if_a.busy};
  assign done_v = {if_b.done, if_a.done};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strip receiver / timing monitor, one lane per instance.
  logic [1:0]   clr = 2'b11;
  logic [255:0] rx_bits [2];
  int rise_cnt [2], first_rise [2], last_rise [2], last_fall [2];
  int done_cyc [2], done_cnt [2], space_err [2], sdo_err [2];
  logic [1:0] prev_sck = 2'b00, prev_sdo = 2'b00;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (clr[k]) begin
        rx_bits[k]    <= '0;
        rise_cnt[k]   <= 0;
        first_rise[k] <= -1;
        last_rise[k]  <= 0;
        last_fall[k]  <= 0;
        done_cyc[k]   <= 0;
        done_cnt[k]   <= 0;
        space_err[k]  <= 0;
        sdo_err[k]    <= 0;
      end else begin
        if (sck_v[k] && !prev_sck[k]) begin
          rx_bits[k][rise_cnt[k]] <= sdo_v[k];
          if (rise_cnt[k] == 0) first_rise[k] <= cyc;
          if ((rise_cnt[k] % 24 != 0) &&
              (cyc - last_rise[k] != 2 * ((k == 0) ? HALF_A : HALF_B)))
            space_err[k] <= space_err[k] + 1;
          last_rise[k] <= cyc;
          rise_cnt[k]  <= rise_cnt[k] + 1;
        end
        if (!sck_v[k] && prev_sck[k]) last_fall[k] <= cyc;
        if (sck_v[k] && (sdo_v[k] != prev_sdo[k])) sdo_err[k] <= sdo_err[k] + 1;
        if (done_v[k]) begin
          done_cyc[k] <= cyc;
          done_cnt[k] <= done_cnt[k] + 1;
        end
      end
      prev_sck[k] <= sck_v[k];
      prev_sdo[k] <= sdo_v[k];
    end
  end

  int n_tests = 0, n_fail = 0;
  int stall_err = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic mon_clear(input int k);
    clr[k] = 1'b1;
    repeat (2) @(negedge clk);
    clr[k] = 1'b0;
  endtask

  task automatic pulse_start(input int k);
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
  endtask

  task automatic wait_ready(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (rdy_v[k]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Feeds n pixels, optionally stalling pix_valid low for 'stall' cycles in LOAD.
  task automatic send_frame(input int k, input int n, input int stall,
                            input logic [23:0] px [5], input bit poke_busy,
                            output int hs_cyc);
    bit ok;
    logic held_sdo;
    hs_cyc = 0;
    for (int p = 0; p < n; p++) begin
      wait_ready(k, ok);
      if (!ok) begin
        chk("pix_ready_timeout", 0, 1);
        return;
      end
      held_sdo = sdo_v[k];
      for (int s = 0; s < stall; s++) begin
        if (sck_v[k] || (sdo_v[k] != held_sdo) || !rdy_v[k]) stall_err++;
        @(negedge clk);
      end
      valid_v[k] = 1'b1;
      data_v[k]  = px[p];
      @(negedge clk);
      valid_v[k] = 1'b0;
      if (p == 0) begin
        hs_cyc = cyc;
        chk("first_bit_sdo", sdo_v[k], px[0][23]);
        chk("ready_drop", rdy_v[k], 0);
      end
      if (poke_busy && (p == 1)) pulse_start(k);
    end
  endtask

  task automatic wait_done(input int k, input bit poke_done, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done_v[k]) begin
        ok = 1'b1;
        if (poke_done) pulse_start(k);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input int k, input int n, input logic [23:0] px [5],
                             input int hs_cyc, input int half, input int lat);
    logic [23:0] v;
    chk("sck_rises", rise_cnt[k], n * 24);
    chk("rise_spacing", space_err[k], 0);
    chk("sdo_stable_high", sdo_err[k], 0);
    chk("first_rise_latency", first_rise[k] - hs_cyc, half);
    chk("latch_time", done_cyc[k] - last_fall[k], lat);
    chk("done_pulses", done_cnt[k], 1);
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 24; b++) v[23 - b] = rx_bits[k][24 * i + b];
      chk($sformatf("led%0d_rgb", i), v, px[i]);
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [23:0] px_a1 [5], px_a2 [5], px_b [5];
  int hs;
  bit ok;
  logic acc;

  initial begin
    px_a1 = '{24'h112233, 24'hA5F00F, 24'hFFF000, 24'hAAAAAA, 24'h0F0F0F};
    px_a2 = '{24'h00FF00, 24'h800001, 24'h7E7E7E, 24'hFFFFFF, 24'h000000};
    px_b  = '{24'hA5F00F, 24'h0, 24'h0, 24'h0, 24'h0};
    start_v = '0;
    valid_v = '0;
    data_v[0] = '0;
    data_v[1] = '0;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_a", {sck_a, sdo_a, busy_v[0], rdy_v[0], done_v[0]}, 0);
    chk("reset_outputs_b", {sck_b, sdo_b, busy_v[1], rdy_v[1], done_v[1]}, 0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    @(negedge clk);

    // Five pixels with stalls, start poked mid-shift and in the done cycle.
    mon_clear(0);
    stall_err = 0;
    pulse_start(0);
    chk("start_busy_ready", {busy_v[0], rdy_v[0]}, 2'b11);
    send_frame(0, LEDS_A, 10, px_a1, 1'b1, hs);
    wait_done(0, 1'b1, ok);
    chk("done_seen_a1", ok, 1);
    acc = 1'b0;
    repeat (10) begin
      acc = acc | busy_v[0] | rdy_v[0];
      @(negedge clk);
    end
    chk("idle_after_done", acc, 0);
    chk("stall_line_held", stall_err, 0);
    check_frame(0, LEDS_A, px_a1, hs, HALF_A, LAT_A);

    // Reset during the 12th bit of the second pixel.
    mon_clear(0);
    valid_v[0] = 1'b1;
    data_v[0]  = 24'h123456;
    pulse_start(0);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (rise_cnt[0] >= 36) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("reached_pixel2_bit12", ok, 1);
    #1 rst_n_a = 1'b0;
    #1 chk("async_reset_outputs", {sck_a, sdo_a, busy_v[0], rdy_v[0], done_v[0]}, 0);
    valid_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n_a = 1'b1;
    @(negedge clk);
    mon_clear(0);
    pulse_start(0);
    send_frame(0, LEDS_A, 0, px_a2, 1'b0, hs);
    wait_done(0, 1'b0, ok);
    chk("done_seen_a2", ok, 1);
    repeat (3) @(negedge clk);
    check_frame(0, LEDS_A, px_a2, hs, HALF_A, LAT_A);

    // Single LED, HALF=1.
    mon_clear(1);
    pulse_start(1);
    send_frame(1, LEDS_B, 0, px_b, 1'b0, hs);
    wait_done(1, 1'b0, ok);
    chk("done_seen_b", ok, 1);
    repeat (3) @(negedge clk);
    check_frame(1, LEDS_B, px_b, hs, HALF_B, LAT_B);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
